// File: rtl/vga_pkg.sv
// Shared VGA text-overlay definitions: character codes, write-command encoding
// and the character-buffer FSM states.
package vga_pkg;

    localparam logic [6:0] Spc   = 7'h20;
    localparam logic [6:0] Zero  = 7'h30;
    localparam logic [6:0] ChrA  = 7'h41;
    localparam logic [6:0] ChrE  = 7'h45;
    localparam logic [6:0] ChrD  = 7'h64;
    localparam logic [6:0] ChrN  = 7'h6E;

    typedef enum logic [1:0] {
        CMD_CHAR    = 2'd0,
        CMD_NEWLINE = 2'd1,
        CMD_GOTO    = 2'd2,
        CMD_NOP     = 2'd3
    } char_cmd_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } char_buf_state_t;

    // Start of the next row; row 15 wraps back to row 0.
    function automatic logic [7:0] next_row(input logic [7:0] addr);
        return {addr[7:4] + 4'd1, 4'h0};
    endfunction

endpackage

// File: rtl/char_ram_256x7.sv
// 256x7 simple dual-port character RAM: one write port, one registered
// read-first read port.
module char_ram_256x7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [6:0] wdata,
    input  logic [7:0] raddr,
    output logic [6:0] rdata
);

    logic [6:0] mem [256];

    // NOTE: the array has no reset so it can map onto block/distributed RAM;
    // contents are initialised by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: non-blocking read and write on the same edge give read-first
    // behaviour: a colliding read returns the previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/char_buf_16x16_wr.sv
// Writable 16x16 character buffer: command stream in over valid/ready,
// char_xy -> char_code lookup out, full-buffer clear after reset or on request.
module char_buf_16x16_wr
    import vga_pkg::*;
#(
    parameter logic [6:0] CLR_CODE = Spc
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  char_cmd_t  wr_cmd,
    input  logic [7:0] wr_data,
    input  logic       clr,
    output logic       busy,
    output logic [7:0] cursor,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code
);

    char_buf_state_t state, state_nxt;
    logic [7:0]      clr_cnt;
    logic            wr_fire;
    logic            ram_we;
    logic [7:0]      ram_waddr;
    logic [6:0]      ram_wdata;

    assign wr_fire = wr_valid && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // A clr seen while clearing is ignored, so a clear always runs 256 cycles.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: if (clr_cnt == 8'hFF) state_nxt = ST_IDLE;
            ST_IDLE:  if (clr)              state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        wr_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = cursor;
        ram_wdata = wr_data[6:0];
        unique case (state)
            ST_CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = CLR_CODE;
            end
            ST_IDLE: begin
                // clr takes priority over a command offered in the same cycle.
                wr_ready = !clr;
                ram_we   = wr_fire && (wr_cmd == CMD_CHAR);
            end
        endcase
    end

    // Held at zero outside CLEAR so every clear starts from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 8'd1;
        end else begin
            clr_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor <= '0;
        end else if (state == ST_CLEAR) begin
            cursor <= '0;
        end else if (wr_fire) begin
            unique case (wr_cmd)
                CMD_CHAR:    cursor <= cursor + 8'd1;
                CMD_NEWLINE: cursor <= next_row(cursor);
                CMD_GOTO:    cursor <= wr_data;
                CMD_NOP:     cursor <= cursor;
            endcase
        end
    end

    char_ram_256x7 u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (char_xy),
        .rdata (char_code)
    );

endmodule

// File: tb/tb_char_buf_16x16_wr.sv
// Scoreboard bench for char_buf_16x16_wr: reads push expected codes into a
// queue, a monitor pops and compares one cycle after each read address.
module tb_char_buf_16x16_wr;
    import vga_pkg::*;

    localparam logic [6:0] SPC = 7'h20;

    typedef struct {
        logic [7:0] addr;
        logic [6:0] exp;
    } rd_exp_t;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    char_cmd_t  wr_cmd;
    logic [7:0] wr_data;
    logic       clr;
    logic       busy;
    logic [7:0] cursor;
    logic [7:0] char_xy;
    logic [6:0] char_code;

    int         tests = 0;
    int         fails = 0;
    rd_exp_t    rd_q[$];
    logic       rd_req   = 1'b0;
    logic       rd_req_d = 1'b0;
    logic [6:0] model_mem [256];
    logic [7:0] model_cur;

    char_buf_16x16_wr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_cmd    (wr_cmd),
        .wr_data   (wr_data),
        .clr       (clr),
        .busy      (busy),
        .cursor    (cursor),
        .char_xy   (char_xy),
        .char_code (char_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a read address captured on an edge is compared after that edge.
    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_req_d) begin
            if (rd_q.size() == 0) begin
                check("rd_queue_underflow", 32'd1, 32'd0);
            end else begin
                e = rd_q.pop_front();
                check($sformatf("rd@%02h", e.addr), {25'd0, char_code}, {25'd0, e.exp});
            end
        end
    end

    task automatic model_fill_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = SPC;
        model_cur = 8'h00;
    endtask

    task automatic model_apply(input char_cmd_t cmd, input logic [7:0] data);
        case (cmd)
            CMD_CHAR: begin
                model_mem[model_cur] = data[6:0];
                model_cur = model_cur + 8'd1;
            end
            CMD_NEWLINE: model_cur = {model_cur[7:4] + 4'd1, 4'h0};
            CMD_GOTO:    model_cur = data;
            default:     ;
        endcase
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_read(input logic [7:0] addr, input logic [6:0] exp);
        char_xy = addr;
        rd_req  = 1'b1;
        rd_q.push_back('{addr: addr, exp: exp});
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic send(input char_cmd_t cmd, input logic [7:0] data, input string name);
        int n = 0;
        wr_cmd   = cmd;
        wr_data  = data;
        wr_valid = 1'b1;
        @(negedge clk);
        while (!wr_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            check({name, "_ready_timeout"}, 32'd0, 32'd1);
            wr_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
            model_apply(cmd, data);
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_fill_clear();
    endtask

    // Counts busy cycles with a command held on the bus; none may be accepted.
    task automatic wait_clear(input string name);
        int n   = 0;
        bit rdy = 1'b0;
        wr_cmd   = CMD_CHAR;
        wr_data  = 8'h5A;
        wr_valid = 1'b1;
        while (n < 600) begin
            @(negedge clk);
            if (!busy) break;
            if (wr_ready) rdy = 1'b1;
            n++;
        end
        wr_valid = 1'b0;
        check({name, "_busy_cycles"}, n, 256);
        check({name, "_ready_during_clear"}, {31'd0, rdy}, 32'd0);
        @(posedge clk);
        #1;
        check({name, "_cursor"}, {24'd0, cursor}, 32'h00);
        check({name, "_ready_after"}, {31'd0, wr_ready}, 32'd1);
        model_fill_clear();
    endtask

    initial begin
        int n;
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        wr_cmd   = CMD_NOP;
        wr_data  = 8'h00;
        clr      = 1'b0;
        char_xy  = 8'h00;
        model_fill_clear();

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_cursor", {24'd0, cursor}, 32'h00);
        check("rst_char_code", {25'd0, char_code}, 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear("por");
        issue_read(8'h00, SPC);
        issue_read(8'h7F, SPC);
        issue_read(8'hFF, SPC);

        // Sequential write "End" across a row boundary
        send(CMD_GOTO, 8'h1E, "goto_1e");
        check("seq_cursor0", {24'd0, cursor}, 32'h1E);
        send(CMD_CHAR, 8'h45, "chr_E");
        check("seq_cursor1", {24'd0, cursor}, 32'h1F);
        send(CMD_CHAR, 8'h6E, "chr_n");
        check("seq_cursor2", {24'd0, cursor}, 32'h20);
        send(CMD_CHAR, 8'hE4, "chr_d");
        check("seq_cursor3", {24'd0, cursor}, 32'h21);
        issue_read(8'h1E, 7'h45);
        issue_read(8'h1F, 7'h6E);
        issue_read(8'h20, 7'h64);

        // Address wrap and newline
        send(CMD_GOTO, 8'hFF, "goto_ff");
        send(CMD_CHAR, 8'h0E, "chr_0e");
        check("wrap_cursor", {24'd0, cursor}, 32'h00);
        issue_read(8'hFF, 7'h0E);
        send(CMD_GOTO, 8'hF5, "goto_f5");
        send(CMD_NEWLINE, 8'h00, "nl_f5");
        check("nl_row15_wrap", {24'd0, cursor}, 32'h00);
        send(CMD_GOTO, 8'h37, "goto_37");
        send(CMD_NEWLINE, 8'h00, "nl_37");
        check("nl_row3", {24'd0, cursor}, 32'h40);
        send(CMD_NOP, 8'h99, "nop");
        check("nop_cursor", {24'd0, cursor}, 32'h40);

        // Read/write collision: old data first, new data the cycle after
        send(CMD_GOTO, 8'h10, "goto_10");
        wr_cmd   = CMD_CHAR;
        wr_data  = 8'h41;
        wr_valid = 1'b1;
        char_xy  = 8'h10;
        rd_req   = 1'b1;
        rd_q.push_back('{addr: 8'h10, exp: SPC});
        @(negedge clk);
        check("coll_ready", {31'd0, wr_ready}, 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        model_apply(CMD_CHAR, 8'h41);
        issue_read(8'h10, 7'h41);
        check("coll_cursor", {24'd0, cursor}, 32'h11);

        // clr beats a simultaneous command; a second clr mid-clear is ignored
        send(CMD_GOTO, 8'hF0, "goto_f0");
        clr      = 1'b1;
        wr_cmd   = CMD_CHAR;
        wr_data  = 8'h55;
        wr_valid = 1'b1;
        char_xy  = 8'hF0;
        rd_req   = 1'b1;
        rd_q.push_back('{addr: 8'hF0, exp: SPC});
        @(negedge clk);
        check("clrprio_ready", {31'd0, wr_ready}, 32'd0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        wr_valid = 1'b0;
        rd_q.push_back('{addr: 8'hF0, exp: SPC});
        n = 0;
        while (n < 600) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n == 2) rd_req = 1'b0;
            clr = (n == 100);
        end
        clr = 1'b0;
        check("clrprio_busy_cycles", n, 256);
        @(posedge clk);
        #1;
        model_fill_clear();
        check("clrprio_cursor", {24'd0, cursor}, 32'h00);
        issue_read(8'hF0, SPC);

        // Asynchronous reset mid-stream
        send(CMD_GOTO, 8'h7F, "goto_7f");
        send(CMD_CHAR, 8'h33, "chr_33");
        send(CMD_CHAR, 8'h34, "chr_34");
        rst_n = 1'b0;
        #2;
        check("midrst_busy", {31'd0, busy}, 32'd1);
        check("midrst_ready", {31'd0, wr_ready}, 32'd0);
        check("midrst_cursor", {24'd0, cursor}, 32'h00);
        check("midrst_char_code", {25'd0, char_code}, 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear("midrst");
        issue_read(8'h00, SPC);
        issue_read(8'h7F, SPC);
        issue_read(8'hFF, SPC);

        // Random stream with stalls and clears, then full RAM dump
        for (int i = 0; i < 1000; i++) begin
            int         r;
            logic [7:0] d;
            char_cmd_t  c;
            if (i == 300 || i == 700) do_clear();
            r = $urandom_range(0, 9);
            d = 8'($urandom_range(0, 255));
            if (r <= 5)      c = CMD_CHAR;
            else if (r == 6) c = CMD_NEWLINE;
            else if (r <= 8) c = CMD_GOTO;
            else             c = CMD_NOP;
            send(c, d, "rnd");
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        check("rnd_cursor", {24'd0, cursor}, {24'd0, model_cur});
        for (int a = 0; a < 256; a++) begin
            issue_read(8'(a), model_mem[a]);
        end
        idle(3);
        check("rd_queue_drained", rd_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
